// File: rtl/wb_reg_file_pkg.sv
// Shared widths, bus types and constants for the writeback-stage register file.
// The optional write-first bypass is enabled by defining REGFILE_WB_BYPASS_EN.
package wb_reg_file_pkg;

    localparam int REGFILE_DATA_WIDTH = 64;
    localparam int REGFILE_ADDR_WIDTH = 5;

    typedef logic [REGFILE_DATA_WIDTH-1:0] data_bus_t;
    typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_file_addr_t;

    localparam reg_file_addr_t REGFILE_ZERO_REG  = '0;
    localparam data_bus_t      REGFILE_RESET_VAL = '0;

endpackage

// File: rtl/wb_reg_file_rdport.sv
// Combinational register-file read mux with x0 masking and an optional
// write-first bypass from the writeback bus.
module wb_reg_file_rdport
    import wb_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter bit BYPASS_EN  = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        data = regs[addr];
        if (BYPASS_EN && wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
        // x0 masking has the final say, even over the bypass
        if (addr == ADDR_WIDTH'(REGFILE_ZERO_REG)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/wb_reg_file.sv
// Integer register file fed by the MEM/WB writeback triple, with two operand
// read ports, a debug port, per-register valid bits and a retired-write counter.
// Define REGFILE_WB_BYPASS_EN for write-first operand reads.
module wb_reg_file
    import wb_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] RdWriteDataIn,
    input  logic [ADDR_WIDTH-1:0] RdAddrIn,
    input  logic                  RdWriteEnableIn,
    input  logic [ADDR_WIDTH-1:0] Rs1Addr,
    input  logic [ADDR_WIDTH-1:0] Rs2Addr,
    output logic [DATA_WIDTH-1:0] Rs1Data,
    output logic [DATA_WIDTH-1:0] Rs2Data,
    input  logic [ADDR_WIDTH-1:0] DbgAddr,
    output logic [DATA_WIDTH-1:0] DbgData,
    output logic                  DbgValid,
    output logic [CNT_WIDTH-1:0]  WriteCount
);

    localparam int NUM_REGS  = 2**ADDR_WIDTH;
    localparam int NUM_PORTS = 3;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]   valid_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic                  commit;
    logic                  bypass_en;

    assign commit    = RdWriteEnableIn && (RdAddrIn != ADDR_WIDTH'(REGFILE_ZERO_REG));
    // No forwarding while reset holds, so every read port reads 0
    assign bypass_en = commit && !Rst;

    // x0 is never written, so its storage stays at the reset value
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= DATA_WIDTH'(REGFILE_RESET_VAL);
            end
            valid_reg <= '0;
            count_reg <= '0;
        end else if (commit) begin
            regs_reg[RdAddrIn]  <= RdWriteDataIn;
            valid_reg[RdAddrIn] <= 1'b1;
            count_reg           <= count_reg + CNT_WIDTH'(1);
        end
    end

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data;

    assign port_addr[0] = Rs1Addr;
    assign port_addr[1] = Rs2Addr;
    assign port_addr[2] = DbgAddr;

    // Ports 0/1 are the decode operands; port 2 is the debug view and never bypasses
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rdport
            wb_reg_file_rdport #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .BYPASS_EN  ((gi < 2) ? BYPASS_EN : 1'b0)
            ) u_rdport (
                .addr    (port_addr[gi]),
                .regs    (regs_reg),
                .wr_en   (bypass_en),
                .wr_addr (RdAddrIn),
                .wr_data (RdWriteDataIn),
                .data    (port_data[gi])
            );
        end
    endgenerate

    assign Rs1Data    = port_data[0];
    assign Rs2Data    = port_data[1];
    assign DbgData    = port_data[2];
    assign DbgValid   = valid_reg[DbgAddr];
    assign WriteCount = count_reg;

endmodule

// File: tb/tb_wb_reg_file.sv
// Randomized self-checking bench for wb_reg_file against an array-based model;
// bypass expectations follow REGFILE_WB_BYPASS_EN.
module tb_wb_reg_file;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int NR = 32;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [DW-1:0] RdWriteDataIn = '0;
    logic [AW-1:0] RdAddrIn = '0;
    logic          RdWriteEnableIn = 1'b0;
    logic [AW-1:0] Rs1Addr = '0;
    logic [AW-1:0] Rs2Addr = '0;
    logic [DW-1:0] Rs1Data;
    logic [DW-1:0] Rs2Data;
    logic [AW-1:0] DbgAddr = '0;
    logic [DW-1:0] DbgData;
    logic          DbgValid;
    logic [CW-1:0] WriteCount;

    always #5 Clk = ~Clk;

    wb_reg_file #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .RdWriteDataIn   (RdWriteDataIn),
        .RdAddrIn        (RdAddrIn),
        .RdWriteEnableIn (RdWriteEnableIn),
        .Rs1Addr         (Rs1Addr),
        .Rs2Addr         (Rs2Addr),
        .Rs1Data         (Rs1Data),
        .Rs2Data         (Rs2Data),
        .DbgAddr         (DbgAddr),
        .DbgData         (DbgData),
        .DbgValid        (DbgValid),
        .WriteCount      (WriteCount)
    );

    logic [DW-1:0] model_regs [NR];
    bit            model_valid [NR];
    int unsigned   model_count;
    int            vectors = 0;
    int            miscompares = 0;
    int            txn = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            model_regs[i]  = '0;
            model_valid[i] = 1'b0;
        end
        model_count = 0;
    endtask

    // Architectural read: x0 is zero, reset forces zero, optional write-first forwarding
    function automatic logic [63:0] exp_read(input logic [AW-1:0] a, input bit bypass);
        if (a == 0) return '0;
        if (bypass && !Rst && RdWriteEnableIn && RdAddrIn == a) return RdWriteDataIn;
        return model_regs[a];
    endfunction

    // Presents one writeback + read set, checks the pre-edge outputs, then commits in the model
    task automatic cycle(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] ad);
        RdWriteEnableIn = we;
        RdAddrIn        = wa;
        RdWriteDataIn   = wd;
        Rs1Addr         = a1;
        Rs2Addr         = a2;
        DbgAddr         = ad;
        #1;
        check("rs1_data", Rs1Data, exp_read(a1, BYPASS));
        check("rs2_data", Rs2Data, exp_read(a2, BYPASS));
        check("dbg_data", DbgData, exp_read(ad, 1'b0));
        check("dbg_valid", 64'(DbgValid), 64'(model_valid[ad]));
        check("write_count", 64'(WriteCount), 64'(model_count % (1 << CW)));
        $display("txn %0d rst=%0b we=%0b wa=%0d wd=%h rs1=%0d:%h rs2=%0d:%h dbg=%0d:%h v=%0b cnt=%0d",
                 txn, Rst, we, wa, wd, a1, Rs1Data, a2, Rs2Data, ad, DbgData, DbgValid, WriteCount);
        txn++;
        @(posedge Clk);
        if (!Rst && we && wa != 0) begin
            model_regs[wa]  = wd;
            model_valid[wa] = 1'b1;
            model_count++;
        end
        @(negedge Clk);
    endtask

    initial begin
        logic [AW-1:0] wa;
        model_clear();
        @(negedge Clk);

        // Reset held under live write traffic: everything reads zero
        for (int a = 0; a < NR; a++) begin
            cycle(1'b1, AW'($urandom), {$urandom, $urandom}, AW'(a), AW'(a), AW'(a));
        end
        Rst = 1'b0;

        // Basic write and read-back
        cycle(1'b1, 5, 64'hDEADBEEF_00000001, 0, 0, 0);
        cycle(1'b0, 0, '0, 5, 5, 5);
        check("basic_x5", Rs1Data, 64'hDEADBEEF_00000001);
        check("basic_count", 64'(WriteCount), 64'd1);

        // x0 protection
        cycle(1'b1, 0, '1, 0, 0, 0);
        cycle(1'b0, 0, '0, 0, 0, 0);
        check("x0_count", 64'(WriteCount), 64'd1);

        // Same-cycle hazard on x7
        cycle(1'b1, 7, 64'h55, 0, 0, 0);
        cycle(1'b1, 7, 64'h1234, 7, 7, 7);
        cycle(1'b0, 0, '0, 7, 7, 7);

        // Random traffic with frequent read/write address collisions
        for (int n = 0; n < 200; n++) begin
            wa = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
            cycle(1'(($urandom_range(0, 3) != 0)), wa, {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom));
        end

        // Counter wrap: 17 commits into a 4-bit counter, interleaved with disabled writes
        Rst = 1'b1;
        model_clear();
        cycle(1'b0, 0, '0, 0, 0, 0);
        Rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, AW'(1 + (i % 31)), {$urandom, $urandom}, AW'($urandom), AW'($urandom), AW'(i + 1));
            cycle(1'b0, AW'(1 + $urandom_range(0, 30)), {$urandom, $urandom}, AW'(i + 1), 0, AW'(i + 1));
        end
        check("wrap_count", 64'(WriteCount), 64'd1);

        // Asynchronous reset asserted between edges after three writes
        cycle(1'b1, 10, {$urandom, $urandom}, 0, 0, 0);
        cycle(1'b1, 11, {$urandom, $urandom}, 0, 0, 0);
        cycle(1'b1, 12, {$urandom, $urandom}, 10, 11, 12);
        #2;
        Rst = 1'b1;
        model_clear();
        cycle(1'b0, 0, '0, 10, 11, 12);

        // A write held across the edge where reset is still high is dropped
        RdWriteEnableIn = 1'b1;
        RdAddrIn        = 9;
        RdWriteDataIn   = 64'hCAFE_F00D_0000_0009;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        cycle(1'b0, 0, '0, 9, 9, 9);
        check("held_write_count", 64'(WriteCount), 64'd0);
        cycle(1'b1, 9, 64'hCAFE_F00D_0000_0009, 0, 0, 0);
        cycle(1'b0, 0, '0, 9, 9, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Integer register file on the receiving end of the MEM/WB pipeline register.
- Consumes the writeback triple (write data, destination address, write enable) registered by MEM/WB and commits it on the clock edge.
- Serves two combinational operand read ports to decode, plus one debug read port.
- Tracks a per-register "written since reset" valid bit and a retired-write counter for bring-up and difftest.

Parameters:
- DATA_WIDTH, 64, width of each architectural register and write data.
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH.
- CNT_WIDTH, 32, width of the retired-write counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- RdWriteDataIn  in  DATA_WIDTH  writeback data from MEM/WB.
- RdAddrIn  in  ADDR_WIDTH  writeback destination register from MEM/WB.
- RdWriteEnableIn  in  1  writeback enable from MEM/WB.
- Rs1Addr  in  ADDR_WIDTH  read port 1 address.
- Rs2Addr  in  ADDR_WIDTH  read port 2 address.
- Rs1Data  out  DATA_WIDTH  read port 1 data, combinational.
- Rs2Data  out  DATA_WIDTH  read port 2 data, combinational.
- DbgAddr  in  ADDR_WIDTH  debug read address.
- DbgData  out  DATA_WIDTH  debug read data, combinational, never bypassed.
- DbgValid  out  1  the addressed register has been written since reset.
- WriteCount  out  CNT_WIDTH  number of committed writes since reset.

Behaviour:
- Reset: Rst is asynchronous and active-high. While high, all registers, all valid bits and WriteCount are forced to 0. Every read output therefore returns 0 during reset; DbgValid returns 0.
- Commit: a write commits when RdWriteEnableIn=1 and RdAddrIn!=0, sampled at the rising Clk edge. Commit updates reg[RdAddrIn], sets valid[RdAddrIn]=1 and increments WriteCount by 1.
- x0: writes with RdAddrIn=0 are dropped with no state change and no count. Reads of address 0 always return 0 on every port.
- Read timing: reads are combinational from array state, with zero latency.
- Same-cycle read of the register being written:
  - without bypass, the read returns the old value;
  - with bypass, it returns RdWriteDataIn (see Optional Feature).
- Both read ports may address the same register; they return identical data.
- WriteCount wraps modulo 2**CNT_WIDTH with no saturation and no flag.
- Rst asserted mid-cycle: the clearing takes effect immediately. A write presented on the edge on which Rst deasserts is not committed if Rst is still high at that edge.
- No handshake or backpressure: every enabled write is accepted on its edge.
- Write data is stored at full DATA_WIDTH with no truncation or sign handling.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: Rs1Data and Rs2Data select RdWriteDataIn when RdWriteEnableIn=1, RdAddrIn!=0 and RdAddrIn equals the port address. This gives write-first semantics and removes one forwarding path from the hazard unit. The x0 rule still returns 0.
- Undefined: reads return array contents only (read-before-write). The hazard/forwarding unit must cover the WB to ID distance. DbgData is unaffected in either case.

Decomposition:
- Shared package/defines: DATA_WIDTH, ADDR_WIDTH, the zero-register index constant, the register reset value (0), and the DataBus/RegFileAddr ranges already used by the pipeline registers.
- One natural sub-module, wb_reg_file_rdport: a combinational read mux with x0 masking and the optional bypass, instantiated three times. The debug instance has bypass forced off.
- Storage, valid bits and the counter stay in the top module.

Test Plan:
- Reset check: assert Rst during traffic, read all 32 addresses on Rs1, Rs2 and Dbg → all return 0, DbgValid=0, WriteCount=0.
- Basic write: write 0xDEADBEEF_00000001 to x5, then on the next cycle read Rs1Addr=5 → Rs1Data=0xDEADBEEF_00000001, DbgValid(5)=1, WriteCount=1.
- x0 protection: write 0xFFFF... to x0 → every read of x0 returns 0, WriteCount unchanged, DbgValid(0)=0.
- Same-cycle hazard: write 0x1234 to x7 while Rs1Addr=Rs2Addr=7 and the old value is 0x55 → both ports read 0x1234 with REGFILE_WB_BYPASS_EN defined, 0x55 without. DbgData reads 0x55 in both builds.
- Counter wrap: with CNT_WIDTH=4, perform 17 writes to x1..x31 → WriteCount=1. Writes with enable=0 do not count.
- Asynchronous reset mid-stream: assert Rst between edges after 3 writes → outputs clear before the next edge. A write held across the reset-deassert edge is not committed.
